// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the instruction-control logic and the PC sequencer:
// jump handshake, return/interrupt requests, and the PC presented to fetch.
interface pc_sequencer_if #(
  parameter int PC_W = 8
);
  logic            jump_valid;
  logic            jump_ready;
  logic [PC_W-1:0] jump_addr;
  logic            jump_call;
  logic            ret_req;
  logic            irq_req;
  logic            irq_ack;
  logic [PC_W-1:0] pc;
  logic            pc_valid;

  // Requester side (instruction control / interrupt source / fetch).
  modport master (
    output jump_valid, jump_addr, jump_call, ret_req, irq_req,
    input  jump_ready, irq_ack, pc, pc_valid
  );

  // Sequencer side.
  modport slave (
    input  jump_valid, jump_addr, jump_call, ret_req, irq_req,
    output jump_ready, irq_ack, pc, pc_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: run/halt/step FSM, interrupt > return > jump > increment arbitration.
// Define PC_SEQ_RETSTACK_EN to build the return-address stack and the sticky err flag.
module pc_sequencer #(
  parameter int              PC_W        = 8,
  parameter int              STEP        = 4,
  parameter logic [PC_W-1:0] IRQ_VECTOR  = PC_W'(8'hF0),
  parameter int              STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         step_req,
  pc_sequencer_if.slave bus,
  output logic [1:0]   state,
  output logic         err
);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [PC_W-1:0] STEP_C = PC_W'(STEP);

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic [PC_W-1:0] inc_s;
  logic [PC_W-1:0] ret_target_s;
  logic            pc_valid_r;
  logic            irq_ack_r;
  logic            irq_mask_r;
  logic            act_s;
  logic            irq_win_s;
  logic            ret_win_s;
  logic            jump_ready_s;
  logic            jump_win_s;

  // Arbitration: an interrupt or return in an active cycle blocks the jump handshake.
  always_comb begin
    inc_s        = pc_r + STEP_C;
    act_s        = (state_r == ST_RUN) || (state_r == ST_STEP);
    irq_win_s    = act_s && bus.irq_req && !irq_mask_r;
    ret_win_s    = act_s && !irq_win_s && bus.ret_req;
    jump_ready_s = act_s && !irq_win_s && !bus.ret_req;
    jump_win_s   = jump_ready_s && bus.jump_valid;
  end

`ifdef PC_SEQ_RETSTACK_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  stack_r [STACK_DEPTH];
  logic [CNT_W-1:0] sp_r;
  logic [IDX_W-1:0] top_idx_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;
  logic             err_r;

  // Stack status and the address a return would restore.
  always_comb begin
    full_s    = (sp_r == CNT_W'(STACK_DEPTH));
    empty_s   = (sp_r == {CNT_W{1'b0}});
    top_idx_s = IDX_W'(sp_r - CNT_W'(1));
    if (irq_win_s) begin
      push_s = 1'b1;
    end else if (jump_win_s && bus.jump_call) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (empty_s) begin
      ret_target_s = inc_s;
    end else begin
      ret_target_s = stack_r[top_idx_s];
    end
  end

  // Return stack storage; overflow drops the entry, underflow falls back to increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_r  <= {CNT_W{1'b0}};
      err_r <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {PC_W{1'b0}};
      end
    end else if (push_s) begin
      if (!full_s) begin
        stack_r[sp_r[IDX_W-1:0]] <= inc_s;
        sp_r                     <= sp_r + CNT_W'(1);
      end else begin
        err_r <= 1'b1;
      end
    end else if (ret_win_s) begin
      if (!empty_s) begin
        sp_r <= sp_r - CNT_W'(1);
      end else begin
        err_r <= 1'b1;
      end
    end
  end

  assign err = err_r;
`else
  // Without a stack, calls are plain jumps and err can never be raised.
  logic [32:0] unused_s;

  assign unused_s     = {bus.jump_call, 32'(STACK_DEPTH)};
  assign ret_target_s = inc_s;
  assign err          = 1'b0;
`endif

  // Next-PC selection in priority order.
  always_comb begin
    if (irq_win_s) begin
      pc_nxt_s = IRQ_VECTOR;
    end else if (ret_win_s) begin
      pc_nxt_s = ret_target_s;
    end else if (jump_win_s) begin
      pc_nxt_s = bus.jump_addr;
    end else if (act_s) begin
      pc_nxt_s = inc_s;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Run/halt/step control; an action in the cycle run drops still completes.
  always_comb begin
    case (state_r)
      ST_HALT: begin
        if (run) begin
          state_nxt_s = ST_RUN;
        end else if (step_req) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_RUN: begin
        if (run) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_STEP: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_HALT;
    endcase
  end

  // PC, strobes, interrupt mask and FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_HALT;
      pc_r       <= {PC_W{1'b0}};
      pc_valid_r <= 1'b0;
      irq_ack_r  <= 1'b0;
      irq_mask_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      pc_valid_r <= act_s;
      irq_ack_r  <= irq_win_s;
      if (irq_win_s) begin
        irq_mask_r <= 1'b1;
      end else if (ret_win_s) begin
        irq_mask_r <= 1'b0;
      end
    end
  end

  assign bus.jump_ready = jump_ready_s;
  assign bus.pc         = pc_r;
  assign bus.pc_valid   = pc_valid_r;
  assign bus.irq_ack    = irq_ack_r;
  assign state          = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized traffic,
// all compared against a queue-based behavioural model.
module tb_pc_sequencer;
  localparam int         PC_W  = 8;
  localparam int         STEP  = 4;
  localparam int         DEPTH = 4;
  localparam logic [7:0] VEC   = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step_req = 1'b0;
  logic [1:0] state;
  logic       err;

  pc_sequencer_if #(.PC_W(PC_W)) bus();

  pc_sequencer #(
    .PC_W(PC_W), .STEP(STEP), .IRQ_VECTOR(VEC), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req),
    .bus(bus), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural state as the PC owner should see it.
  logic [7:0] m_pc = 8'h00;
  int         m_state = 0;
  bit         m_mask = 1'b0;
  bit         m_err = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_ack = 1'b0;
  logic [7:0] m_stack[$];
  bit         jpend = 1'b0;

  function automatic bit m_active();
    return (m_state == 1) || (m_state == 2);
  endfunction

  function automatic bit m_ready();
    return m_active() && !(bus.irq_req && !m_mask) && !bus.ret_req;
  endfunction

  task automatic m_push(input logic [7:0] v);
`ifdef PC_SEQ_RETSTACK_EN
    if (m_stack.size() < DEPTH) m_stack.push_back(v);
    else m_err = 1'b1;
`else
    v = v;
`endif
  endtask

  task automatic model_edge();
    logic [7:0] inc;
    if (!rst_n) begin
      m_pc = 8'h00; m_state = 0; m_mask = 1'b0; m_err = 1'b0;
      m_valid = 1'b0; m_ack = 1'b0; m_stack.delete();
      return;
    end
    inc     = m_pc + 8'(STEP);
    m_valid = m_active();
    m_ack   = 1'b0;
    if (m_valid) begin
      if (bus.irq_req && !m_mask) begin
        m_push(inc); m_pc = VEC; m_mask = 1'b1; m_ack = 1'b1;
      end else if (bus.ret_req) begin
`ifdef PC_SEQ_RETSTACK_EN
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = inc; m_err = 1'b1; end
`else
        m_pc = inc;
`endif
        m_mask = 1'b0;
      end else if (bus.jump_valid) begin
        m_pc = bus.jump_addr;
        if (bus.jump_call) m_push(inc);
      end else begin
        m_pc = inc;
      end
    end
    case (m_state)
      0:       m_state = run ? 1 : (step_req ? 2 : 0);
      1:       m_state = run ? 1 : 0;
      default: m_state = 0;
    endcase
  endtask

  // One clock: check the combinational handshake, clock, then check registered outputs.
  task automatic tick();
    #1;
    check_eq("jump_ready", bus.jump_ready, m_ready());
    jpend = rst_n && bus.jump_valid && !m_ready();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("pc", bus.pc, m_pc);
    check_eq("pc_valid", bus.pc_valid, m_valid);
    check_eq("irq_ack", bus.irq_ack, m_ack);
    check_eq("state", state, m_state);
    check_eq("err", err, m_err);
  endtask

  initial begin
    bus.jump_valid = 1'b0; bus.jump_addr = 8'h00; bus.jump_call = 1'b0;
    bus.ret_req = 1'b0; bus.irq_req = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset values
    rst_n = 1'b0; tick(); tick();
    check_eq("rst_pc", bus.pc, 8'h00);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_valid", bus.pc_valid, 1'b0);
    check_eq("rst_err", err, 1'b0);

    // Reset and run: 0,4,8,12
    rst_n = 1'b1; run = 1'b1;
    tick(); check_eq("run_pc0", bus.pc, 8'h00); check_eq("run_valid0", bus.pc_valid, 1'b0);
    tick(); check_eq("run_pc4", bus.pc, 8'h04); check_eq("run_valid1", bus.pc_valid, 1'b1);
    tick(); check_eq("run_pc8", bus.pc, 8'h08);
    tick(); check_eq("run_pc12", bus.pc, 8'h0C);
    run = 1'b0;
    tick(); check_eq("halt_last_action", bus.pc, 8'h10); check_eq("halt_state", state, 2'd0);

    // Single step: one update two edges after the pulse
    step_req = 1'b1; tick();
    check_eq("step_state", state, 2'd2); check_eq("step_pc_hold", bus.pc, 8'h10);
    step_req = 1'b0; tick();
    check_eq("step_pc", bus.pc, 8'h14); check_eq("step_back_halt", state, 2'd0);
    tick();
    check_eq("step_no_more", bus.pc, 8'h14); check_eq("step_valid_off", bus.pc_valid, 1'b0);

    // Wrap
    run = 1'b1; tick();
    bus.jump_valid = 1'b1; bus.jump_addr = 8'hFC; tick();
    check_eq("jump_fc", bus.pc, 8'hFC);
    bus.jump_valid = 1'b0; tick();
    check_eq("wrap", bus.pc, 8'h00);

    // Interrupt beats a simultaneous jump; the jump stays pending
    bus.jump_valid = 1'b1; bus.jump_addr = 8'h40; bus.irq_req = 1'b1;
    #1 check_eq("irq_blocks_jump", bus.jump_ready, 1'b0);
    tick();
    check_eq("irq_vector", bus.pc, 8'hF0); check_eq("irq_ack_pulse", bus.irq_ack, 1'b1);
    tick();
    check_eq("pending_jump", bus.pc, 8'h40); check_eq("irq_ack_once", bus.irq_ack, 1'b0);
    bus.jump_valid = 1'b0; bus.irq_req = 1'b0;
    bus.ret_req = 1'b1; tick(); bus.ret_req = 1'b0;
`ifdef PC_SEQ_RETSTACK_EN
    check_eq("irq_return", bus.pc, 8'h04);

    // Call / return
    bus.jump_valid = 1'b1; bus.jump_addr = 8'h10; tick();
    bus.jump_call = 1'b1; bus.jump_addr = 8'h80; tick();
    check_eq("call_target", bus.pc, 8'h80);
    bus.jump_valid = 1'b0; bus.jump_call = 1'b0; bus.ret_req = 1'b1; tick();
    check_eq("call_return", bus.pc, 8'h14);
    bus.ret_req = 1'b0;

    // Five nested calls overflow; five returns underflow on the last
    bus.jump_valid = 1'b1; bus.jump_call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.jump_addr = 8'(8'h20 + 8'(i) * 8'h10);
      tick();
      if (i == 3) check_eq("no_err_at_4", err, 1'b0);
    end
    check_eq("overflow_err", err, 1'b1);
    bus.jump_valid = 1'b0; bus.jump_call = 1'b0; bus.ret_req = 1'b1;
    tick(); check_eq("ret1", bus.pc, 8'h44);
    tick(); check_eq("ret2", bus.pc, 8'h34);
    tick(); check_eq("ret3", bus.pc, 8'h24);
    tick(); check_eq("ret4", bus.pc, 8'h18);
    tick(); check_eq("ret_underflow", bus.pc, 8'h1C); check_eq("err_sticky", err, 1'b1);
    bus.ret_req = 1'b0;
`else
    check_eq("ret_no_stack", bus.pc, 8'h44);
    bus.jump_valid = 1'b1; bus.jump_call = 1'b1; bus.jump_addr = 8'h80; tick();
    bus.jump_valid = 1'b0; bus.jump_call = 1'b0; bus.ret_req = 1'b1; tick();
    check_eq("ret_increments", bus.pc, 8'h84); check_eq("err_tied", err, 1'b0);
    bus.ret_req = 1'b0;
`endif

    // Randomized traffic with occasional resets and halt phases
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 249) != 0);
      run      = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 8 : 3));
      step_req = ($urandom_range(0, 4) == 0);
      bus.irq_req = ($urandom_range(0, 9) == 0);
      bus.ret_req = ($urandom_range(0, 7) == 0);
      if (!jpend) begin
        bus.jump_valid = ($urandom_range(0, 2) == 0);
        bus.jump_addr  = 8'($urandom);
        bus.jump_call  = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
